// File: rtl/data_ram_arbiter_pkg.sv
// Shared types for the data RAM arbiter.
//   arb_state_t : which read, if any, is returning from the RAM this cycle.
//   ram_port_t  : the muxed RAM-side request (address, write data, write enable).
package pcpu;

  localparam int RAM_ADDR_W = 10;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_DBG_RD = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
    logic                  we;
  } ram_port_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and asynchronous active-high reset (count -> 0)
//   inc      : count up by one unless already at LIMIT
//   clr      : clear to zero; wins over inc
//   cnt      : current count (registered)
module arb_age_counter #(
  parameter int           W     = 8,
  parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, otherwise step up and stick at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between the CPU data path (read/write,
// priority) and the VGA debug viewer (read-only). An aging counter forces a
// viewer grant after MAX_WAIT refused cycles; the CPU then sees a stall.
//   cpu_*        : CPU request/grant/stall and read return
//   dbg_*        : viewer request/grant and read return
//   ram_*        : muxed RAM port; ram_dout arrives one cycle after its address
//   conflict_cnt : saturating count of cycles with both requests present
// ADDR_W/DATA_W are expected to match the pcpu RAM port widths.
module data_ram_arbiter
  import pcpu::*;
#(
  parameter int ADDR_W   = pcpu::RAM_ADDR_W,
  parameter int DATA_W   = pcpu::RAM_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [15:0]       conflict_cnt
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  arb_state_t owner_q;
  arb_state_t owner_d;
  logic [7:0] wait_q;
  ram_port_t  port_s;
  logic       dbg_gnt_s;
  logic       cpu_gnt_s;

  // Grant decision: CPU wins unless the viewer has aged out.
  always_comb begin
    dbg_gnt_s = 1'b0;
    cpu_gnt_s = 1'b0;
    if (dbg_req && (!cpu_req || (wait_q == WAIT_LIMIT))) begin
      dbg_gnt_s = 1'b1;
    end else begin
      dbg_gnt_s = 1'b0;
    end
    cpu_gnt_s = cpu_req & ~dbg_gnt_s;
  end

  // RAM port mux; idle cycles still present the CPU address with we low.
  always_comb begin
    port_s = '0;
    if (dbg_gnt_s) begin
      port_s.addr = RAM_ADDR_W'(dbg_addr);
    end else begin
      port_s.addr = RAM_ADDR_W'(cpu_addr);
    end
    port_s.wdata = RAM_DATA_W'(cpu_wdata);
    port_s.we    = cpu_gnt_s & cpu_we;
  end

  // Record which read, if any, returns next cycle. Writes return nothing.
  always_comb begin
    owner_d = ST_IDLE;
    if (dbg_gnt_s) begin
      owner_d = ST_DBG_RD;
    end else if (cpu_gnt_s && !cpu_we) begin
      owner_d = ST_CPU_RD;
    end else begin
      owner_d = ST_IDLE;
    end
  end

  // Owner register; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= ST_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Route returning RAM data to its owner; the other side sees zero.
  always_comb begin
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    cpu_rdata  = {DATA_W{1'b0}};
    dbg_rdata  = {DATA_W{1'b0}};
    case (owner_q)
      ST_CPU_RD: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = ram_dout;
      end
      ST_DBG_RD: begin
        dbg_rvalid = 1'b1;
        dbg_rdata  = ram_dout;
      end
      ST_IDLE: begin
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
      end
      default: begin
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
      end
    endcase
  end

  // Viewer aging: counts refused cycles, holds while the viewer is quiet.
  arb_age_counter #(
    .W     (8),
    .LIMIT (WAIT_LIMIT)
  ) u_wait (
    .clk (clk),
    .rst (rst),
    .inc (dbg_req & ~dbg_gnt_s),
    .clr (dbg_gnt_s),
    .cnt (wait_q)
  );

  // Contention statistics.
  arb_age_counter #(
    .W     (16),
    .LIMIT (16'hFFFF)
  ) u_conflict (
    .clk (clk),
    .rst (rst),
    .inc (cpu_req & dbg_req),
    .clr (1'b0),
    .cnt (conflict_cnt)
  );

  assign dbg_gnt   = dbg_gnt_s;
  assign cpu_gnt   = cpu_gnt_s;
  assign cpu_stall = cpu_req & ~cpu_gnt_s;
  assign ram_addr  = ADDR_W'(port_s.addr);
  assign ram_din   = DATA_W'(port_s.wdata);
  assign ram_we    = port_s.we;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomised scoreboard bench for data_ram_arbiter with a behavioural RAM.
module tb_data_ram_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0]  cpu_addr = 10'h155;
  logic [31:0] cpu_wdata = 32'h0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0;
  logic [9:0]  dbg_addr = 10'h0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;
  logic [15:0] conflict_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];

  // Reference model state
  bit [31:0] ref_mem [1024];
  int        ref_wait = 0;
  int        ref_conf = 0;

  // Behavioural RAM (read-first, one-cycle latency)
  bit [31:0] mem [1024];

  data_ram_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected read data whenever a return is due.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
        e = cpu_q.pop_front();
        chk("cpu_rvalid", {63'd0, cpu_rvalid}, 64'd1);
        chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.data});
      end else begin
        chk("cpu_idle_ret", {31'd0, cpu_rvalid, cpu_rdata}, 64'd0);
      end
      if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
        e = dbg_q.pop_front();
        chk("dbg_rvalid", {63'd0, dbg_rvalid}, 64'd1);
        chk("dbg_rdata", {32'd0, dbg_rdata}, {32'd0, e.data});
      end else begin
        chk("dbg_idle_ret", {31'd0, dbg_rvalid, dbg_rdata}, 64'd0);
      end
    end
  end

  // One cycle: check combinational outputs against the model, advance model.
  task automatic step();
    logic eg_d, eg_c;
    #1;
    eg_d = dbg_req && (!cpu_req || ref_wait >= MAX_WAIT);
    eg_c = cpu_req && !eg_d;
    chk("dbg_gnt",   {63'd0, dbg_gnt},   {63'd0, eg_d});
    chk("cpu_gnt",   {63'd0, cpu_gnt},   {63'd0, eg_c});
    chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, cpu_req && !eg_c});
    chk("ram_we",    {63'd0, ram_we},    {63'd0, eg_c && cpu_we});
    chk("ram_addr",  {54'd0, ram_addr},  {54'd0, eg_d ? dbg_addr : cpu_addr});
    chk("ram_din",   {32'd0, ram_din},   {32'd0, cpu_wdata});
    chk("conflict_cnt", {48'd0, conflict_cnt}, 64'(ref_conf));
    chk("wait_q",    {56'd0, dut.wait_q}, 64'(ref_wait));
    if (eg_d) dbg_q.push_back('{cyc + 1, ref_mem[dbg_addr]});
    if (eg_c && !cpu_we) cpu_q.push_back('{cyc + 1, ref_mem[cpu_addr]});
    if (eg_c && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (eg_d) ref_wait = 0;
    else if (dbg_req && ref_wait < MAX_WAIT) ref_wait = ref_wait + 1;
    if (cpu_req && dbg_req && ref_conf < 65535) ref_conf = ref_conf + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    chk("rst_gnts", {60'd0, cpu_gnt, dbg_gnt, cpu_stall, ram_we}, 64'd0);
    chk("rst_ram_addr", {54'd0, ram_addr}, 64'h155);
    chk("rst_rvalid", {62'd0, cpu_rvalid, dbg_rvalid}, 64'd0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 64'd0);
    chk("rst_conflict", {48'd0, conflict_cnt}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // CPU only: fill low addresses, then the DEADBEEF write/read pair
    for (int i = 0; i < 16; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'(i); cpu_wdata = $urandom;
      step();
    end
    cpu_addr = 10'd5; cpu_wdata = 32'hDEADBEEF;
    step();
    cpu_we = 1'b0;
    step();
    cpu_req = 1'b0;
    step();

    // Viewer only: addresses 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      dbg_req = 1'b1; dbg_addr = 10'(i);
      step();
    end
    dbg_req = 1'b0;
    step();

    // Sustained contention, random CPU traffic
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 27; i++) begin
      cpu_we = 1'($urandom); cpu_addr = 10'($urandom_range(0, 15));
      cpu_wdata = $urandom; dbg_addr = 10'($urandom_range(0, 15));
      step();
    end

    // Forced viewer grant against a CPU write to address 7
    cpu_we = 1'b0;
    for (int i = 0; i < 20 && ref_wait != MAX_WAIT; i++) step();
    chk("age_reached", 64'(ref_wait), 64'(MAX_WAIT));
    cpu_we = 1'b1; cpu_addr = 10'd7; cpu_wdata = 32'hCAFEF00D; dbg_addr = 10'd7;
    step();
    dbg_req = 1'b0;
    step();
    cpu_we = 1'b0;
    step();

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      cpu_req = 1'($urandom); dbg_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 10'($urandom_range(0, 31)); dbg_addr = 10'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      step();
    end

    // Async reset the cycle after a viewer grant
    cpu_req = 1'b1; dbg_req = 1'b1;
    step();
    cpu_req = 1'b0; dbg_addr = 10'd3;
    step();
    dbg_req = 1'b0;
    rst = 1'b1;
    cpu_q.delete(); dbg_q.delete();
    ref_wait = 0; ref_conf = 0;
    #1;
    chk("rst_mid_dbg_rvalid", {31'd0, dbg_rvalid, dbg_rdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_wait", {56'd0, dut.wait_q}, 64'd0);
    chk("rst_mid_conflict", {48'd0, conflict_cnt}, 64'd0);
    step();

    // Saturation of the conflict counter
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      cpu_addr = 10'($urandom_range(0, 15)); dbg_addr = 10'($urandom_range(0, 15));
      step();
    end
    chk("conflict_sat", {48'd0, conflict_cnt}, 64'hFFFF);

    cpu_req = 1'b0; dbg_req = 1'b0;
    step();
    step();
    chk("queues_drained", 64'(cpu_q.size() + dbg_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Arbitrates the single-port data RAM between two requesters: the CPU data path (through the MIO bus, read/write) and the VGA debug memory viewer (read-only). It sits between the bus decoder and the RAM. The CPU has priority, with an aging counter that guarantees the viewer a slot after a bounded wait. When the CPU loses a cycle it receives a stall, and the pipeline holds its memory-stage request.

## Interface
- `ADDR_W`, default 10: RAM word-address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 8: cycles the viewer may be refused before it must win (1..255).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request, held until granted.
- `cpu_we` in 1: CPU write enable, qualified by `cpu_req`.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: CPU access performed this cycle.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out DATA_W: CPU read data.
- `dbg_req` in 1: viewer read request, held until granted.
- `dbg_addr` in ADDR_W: viewer word address.
- `dbg_gnt` out 1: viewer read issued this cycle.
- `dbg_rvalid` out 1: viewer read data valid.
- `dbg_rdata` out DATA_W: viewer read data.
- `ram_addr` out ADDR_W: RAM address.
- `ram_din` out DATA_W: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in DATA_W: RAM read data, valid one cycle after its address.
- `conflict_cnt` out 16: saturating count of cycles with both requests asserted.

## Operation
- Grant decision is combinational from the current requests, the aging counter `wait_q` and the state.
  - `dbg_gnt = dbg_req & (~cpu_req | wait_q == MAX_WAIT)`.
  - `cpu_gnt = cpu_req & ~dbg_gnt`.
  - Only one grant is ever issued per cycle.
- RAM port muxing:
  - `ram_addr`: `dbg_addr` when `dbg_gnt`, else `cpu_addr`. When neither is granted it still drives `cpu_addr`, with `ram_we` low.
  - `ram_we = cpu_gnt & cpu_we`.
  - `ram_din = cpu_wdata`.
- State register `owner_q` (ST_IDLE, ST_CPU_RD, ST_DBG_RD) records the read in flight:
  - ST_CPU_RD if `cpu_gnt & ~cpu_we`.
  - ST_DBG_RD if `dbg_gnt`.
  - Otherwise ST_IDLE; a CPU write leaves the state at ST_IDLE.
- Read return:
  - `cpu_rvalid = (owner_q == ST_CPU_RD)`.
  - `dbg_rvalid = (owner_q == ST_DBG_RD)`.
  - Each rdata equals `ram_dout` while its rvalid is high, else 0.
- Aging counter `wait_q` (8-bit):
  - Increments when `dbg_req & ~dbg_gnt`, saturating at MAX_WAIT.
  - Clears to 0 on `dbg_gnt`.
  - Holds when `dbg_req` is low.
- `conflict_cnt` increments when `cpu_req & dbg_req`, saturating at 16'hFFFF.
- Back-to-back grants to either side are allowed every cycle. A new grant in the cycle where an earlier read returns is legal and required.

## Timing
- Reset values: `owner_q` = ST_IDLE, `wait_q` = 0, `conflict_cnt` = 0. Hence both rvalid = 0 and both rdata = 0.
- Gnt, stall and the `ram_*` outputs are combinational and depend only on inputs and state. With no requests during reset they are all 0, with `ram_addr = cpu_addr`.
- Read latency: grant in cycle N gives rvalid and rdata in cycle N+1. Write completes at the edge ending cycle N.
- Starvation bound: with `cpu_req` held high, a continuously requesting viewer is granted in cycle MAX_WAIT+1 after its request rises. The CPU is stalled exactly that one cycle.
- Simultaneous events:
  - When aging forces a viewer grant, a CPU write pending in the same cycle is not performed; the CPU re-presents it next cycle.
  - A request that drops without a grant loses nothing, and `wait_q` holds.
- Reset mid-read: the in-flight rvalid is suppressed and the data is dropped. Requesters must re-issue.

## Structure
- Add to package `pcpu`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_CPU_RD, ST_DBG_RD} arb_state_t`.
  - A `ram_port_t` struct (addr, wdata, we) for the muxed RAM side.
- Sub-module `arb_age_counter`: the saturating wait counter, parameterised on width and limit. Instantiated once for `wait_q` and reused for `conflict_cnt`, with width 16 and limit 16'hFFFF.

## Test plan
- CPU only: write 0xDEADBEEF to address 5, then read address 5.
  - Write cycle: `cpu_gnt` = 1, `ram_we` = 1.
  - Next cycle after the read grant: `cpu_rvalid` = 1, `cpu_rdata` = 0xDEADBEEF; `cpu_stall` never asserted.
- Viewer only: reads at addresses 0..3 on consecutive cycles.
  - `dbg_rvalid` high 4 consecutive cycles, each one cycle after its grant; data in order.
- Sustained contention, MAX_WAIT = 8: both requests held.
  - CPU granted 8 cycles, then viewer 1 cycle with `cpu_stall` = 1 and `wait_q` back to 0; the pattern repeats.
  - `conflict_cnt` rises by 1 per cycle.
- Forced grant against a CPU write: at `wait_q` = MAX_WAIT the CPU presents a write to address 7.
  - `ram_we` = 0 that cycle; the write lands the next cycle.
  - A viewer read of address 7 issued in the forced cycle returns the old value.
- Async reset asserted the cycle after a viewer grant: `dbg_rvalid` stays 0; `wait_q` and `conflict_cnt` read 0 after release.
- Saturation: force 70000 contention cycles; `conflict_cnt` holds 0xFFFF.
